// File: rtl/neuron_lut_loader.sv
// neuron_lut_loader: runtime-loadable 64x2 neuron truth table.
// A 16-byte valid/ready stream fills a shadow copy. A correctly framed load
// commits it atomically to the active table. Lookups are registered and
// read the active table.
module neuron_lut_loader #(
  parameter int ENTRIES = 64,
  parameter int OUT_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_valid,
  input  logic             cfg_last,
  output logic             cfg_ready,
  input  logic [5:0]       M0,
  input  logic             in_valid,
  output logic [OUT_W-1:0] M1,
  output logic             out_valid,
  output logic             loaded,
  output logic             cfg_err
);

  localparam int PER_BYTE = 8 / OUT_W;          // entries per config byte
  localparam int NBYTES   = ENTRIES / PER_BYTE; // bytes per full load
  localparam int IW       = $clog2(NBYTES);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                          state, state_d;
  logic [IW-1:0]                   idx, idx_d, widx;
  logic                            cfg_err_d, loaded_d, commit, wr_en, acc;
  logic [ENTRIES-1:0][OUT_W-1:0]   active, shadow, shadow_nx;

  // The block can take a byte whenever it is out of reset.
  assign cfg_ready = rst;
  assign acc       = cfg_valid & cfg_ready;

  // Per-byte lanes: merge the incoming byte into its shadow slot. The commit
  // copies shadow_nx so that the final byte lands in the same edge.
  for (genvar b = 0; b < NBYTES; b++) begin : g_lane
    assign shadow_nx[b*PER_BYTE +: PER_BYTE] =
      (wr_en && widx == IW'(b)) ? cfg_data : shadow[b*PER_BYTE +: PER_BYTE];
  end

  // Load framing: next state, byte index, error/loaded flags, commit strobe.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cfg_err_d = cfg_err;
    loaded_d  = loaded;
    commit    = 1'b0;
    wr_en     = 1'b0;
    widx      = '0;
    case (state)
      IDLE: begin
        if (acc) begin
          wr_en     = 1'b1;
          widx      = '0;
          cfg_err_d = 1'b0;
          if (cfg_last) begin
            // A single-byte "load" is a framing error.
            cfg_err_d = 1'b1;
            idx_d     = '0;
          end else begin
            idx_d   = IW'(1);
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (acc) begin
          wr_en = 1'b1;
          widx  = idx;
          if (idx == IW'(NBYTES - 1)) begin
            if (cfg_last) begin
              commit   = 1'b1;
              loaded_d = 1'b1;
            end else begin
              cfg_err_d = 1'b1;
            end
            idx_d   = '0;
            state_d = IDLE;
          end else if (cfg_last) begin
            // Early last: drop the load and keep the active table as it is.
            cfg_err_d = 1'b1;
            idx_d     = '0;
            state_d   = IDLE;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Loader state, shadow/active tables and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      cfg_err <= 1'b0;
      loaded  <= 1'b0;
      shadow  <= '0;
      active  <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cfg_err <= cfg_err_d;
      loaded  <= loaded_d;
      shadow  <= shadow_nx;
      if (commit) active <= shadow_nx;
    end
  end

  // Registered lookup. A lookup in the commit cycle sees the old table.
  always_ff @(posedge clk) begin
    if (!rst) begin
      M1        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) M1 <= loaded ? active[M0] : '0;
    end
  end

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Directed bench for neuron_lut_loader. The expected values are computed by hand.
module tb_neuron_lut_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_data;
  logic       cfg_valid, cfg_last, cfg_ready;
  logic [5:0] M0;
  logic       in_valid;
  logic [1:0] M1;
  logic       out_valid, loaded, cfg_err;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  neuron_lut_loader #(.ENTRIES(64), .OUT_W(2)) dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_last(cfg_last),
    .cfg_ready(cfg_ready),
    .M0(M0), .in_valid(in_valid), .M1(M1), .out_valid(out_valid),
    .loaded(loaded), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic lookup(input logic [5:0] code);
    in_valid = 1'b1;
    M0       = code;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_data = '0; cfg_valid = 1'b0; cfg_last = 1'b0;
    M0 = '0; in_valid = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_M1", M1, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_loaded", loaded, 0);
    check("rst_cfg_err", cfg_err, 0);

    // Lookup before any table is loaded
    rst = 1'b1;
    check("cfg_ready_up", cfg_ready, 1);
    lookup(6'd37);
    check("unloaded_M1", M1, 0);
    check("unloaded_out_valid", out_valid, 1);
    check("unloaded_loaded", loaded, 0);

    // Full load of E4 bytes, then a back-to-back sweep
    for (int k = 0; k < 15; k++) send(8'hE4, 1'b0);
    check("precommit_loaded", loaded, 0);
    send(8'hE4, 1'b1);
    check("commit_loaded", loaded, 1);
    check("commit_cfg_err", cfg_err, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      M0 = 6'(i);
      tick();
      check("sweep_e4", M1, 8'(i % 4));
      check("sweep_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    tick();
    check("idle_out_valid", out_valid, 0);
    check("idle_M1_hold", M1, 3);

    // Early cfg_last on byte 7
    for (int k = 0; k < 7; k++) send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    check("early_last_err", cfg_err, 1);
    check("early_last_loaded", loaded, 1);
    lookup(6'd3);
    check("early_last_M0_3", M1, 3);
    send(8'h00, 1'b0);   // first byte of the next load
    check("err_cleared", cfg_err, 0);

    // Missing cfg_last on byte 15 (byte 15 = FF)
    for (int k = 1; k < 15; k++) send(8'h00, 1'b0);
    check("pre15_err", cfg_err, 0);
    send(8'hFF, 1'b0);
    check("nolast_err", cfg_err, 1);
    check("nolast_loaded", loaded, 1);
    lookup(6'd3);
    check("nolast_M0_3", M1, 3);
    lookup(6'd4);
    check("nolast_M0_4", M1, 0);
    lookup(6'd6);
    check("nolast_M0_6", M1, 2);

    // Commit FF table while looking up code 5 in the commit cycle
    for (int k = 0; k < 15; k++) send(8'hFF, 1'b0);
    cfg_valid = 1'b1; cfg_data = 8'hFF; cfg_last = 1'b1;
    in_valid = 1'b1; M0 = 6'd5;
    tick();
    cfg_valid = 1'b0; cfg_last = 1'b0;
    check("commit_cycle_old", M1, 1);
    check("commit_cycle_err", cfg_err, 0);
    tick();
    in_valid = 1'b0;
    check("after_commit_new", M1, 3);

    // Stalled load of 1B bytes (entry j of each byte = 3-j)
    for (int k = 0; k < 7; k++) send(8'h1B, 1'b0);
    for (int s = 0; s < 10; s++) begin
      in_valid = 1'b1; M0 = 6'd30;
      tick();
    end
    in_valid = 1'b0;
    check("stall_old_table", M1, 3);
    check("stall_err", cfg_err, 0);
    for (int k = 7; k < 15; k++) send(8'h1B, 1'b0);
    send(8'h1B, 1'b1);
    check("stall_commit_err", cfg_err, 0);
    in_valid = 1'b1;
    for (int i = 24; i < 64; i++) begin
      M0 = 6'(i);
      tick();
      check("sweep_1b", M1, 8'(3 - (i % 4)));
    end
    in_valid = 1'b0;

    // Reset in the middle of a load
    lookup(6'd24);
    check("pre_reset_M1", M1, 3);
    for (int k = 0; k < 10; k++) send(8'hE4, 1'b0);
    rst = 1'b0; in_valid = 1'b1; M0 = 6'd1;
    tick();
    check("midrst_M1", M1, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_loaded", loaded, 0);
    check("midrst_cfg_err", cfg_err, 0);
    check("midrst_cfg_ready", cfg_ready, 0);
    rst = 1'b1;
    lookup(6'd0);
    check("postrst_M1", M1, 0);
    check("postrst_out_valid", out_valid, 1);
    check("postrst_loaded", loaded, 0);
    check("postrst_cfg_err", cfg_err, 0);

    // A fresh load after reset frames from byte 0
    for (int k = 0; k < 15; k++) send(8'hE4, 1'b0);
    send(8'hE4, 1'b1);
    check("reload_loaded", loaded, 1);
    lookup(6'd6);
    check("reload_M0_6", M1, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/neuron_lut_loader.md
# neuron_lut_loader

Runtime-programmable 64-entry x 2-bit neuron truth table for layer-0 LogicNets neurons (6-bit input code, 2-bit output code). The block is the writer side of the neuron ROM interface. It accepts a 128-bit truth table as a 16-byte valid/ready stream into a shadow buffer and commits it atomically when a correctly framed load completes. It serves registered lookups from the committed table. A design can use it in place of a fixed neuron ROM to retarget the model without resynthesis.

## Interface
- `ENTRIES`, default 64: table depth; fixed at 64, equal to 2^6 input codes.
- `OUT_W`, default 2: output code width; fixed at 2.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset; synchronous and active-low.
- `cfg_data` input, 8 bits: table byte. Bits [2j+1:2j] hold the entry for input code 4*k+j, where k is the byte index (0..15).
- `cfg_valid` input, 1 bit: `cfg_data` is valid.
- `cfg_last` input, 1 bit: marks the final byte of a load.
- `cfg_ready` output, 1 bit: the block can accept a byte.
- `M0` input, 6 bits: lookup code, read as an unsigned index 0..63.
- `in_valid` input, 1 bit: lookup request.
- `M1` output, 2 bits: lookup result.
- `out_valid` output, 1 bit: `M1` is valid.
- `loaded` output, 1 bit: a committed table exists.
- `cfg_err` output, 1 bit: sticky framing-error flag.

## Operation
- Storage:
  - Active table: 64x2 bits.
  - Shadow table: 64x2 bits.
  - Byte index: 4-bit `idx`.
- States:
  - IDLE: no load in progress.
  - LOAD: collecting bytes.
- A byte is accepted when `cfg_valid && cfg_ready`. `cfg_ready` is 1 in both states whenever `rst` is 1.
- IDLE, accepted byte:
  - Write the byte into shadow entries 0..3.
  - Set `idx` to 1 and clear `cfg_err`.
  - If `cfg_last` is 1, this is a framing error (see the error rule below) and the state stays IDLE. Otherwise go to LOAD.
- LOAD, accepted byte with `idx` < 15:
  - Write shadow entries 4*idx..4*idx+3.
  - If `cfg_last` is 1, framing error. Otherwise increment `idx`.
- LOAD, accepted byte with `idx` = 15:
  - If `cfg_last` is 1: copy the shadow table, including this byte, into the active table in the same edge. Set `loaded` to 1 and go to IDLE.
  - If `cfg_last` is 0: framing error.
- Framing-error rule:
  - Set `cfg_err` to 1 and go to IDLE with `idx` = 0.
  - Leave the active table and `loaded` unchanged; discard the shadow contents.
- Lookup:
  - Each cycle, `out_valid` is registered from `in_valid`.
  - `M1` is registered as `active[M0]` when `loaded` is 1, else 2'b00.
  - When `in_valid` is 0, `M1` holds its previous value.
- Lookups and loads are fully concurrent. A lookup in the same cycle as a commit reads the pre-commit active table.
- `cfg_err` stays set until the first accepted byte of the next load, or until reset.

## Timing
- Reset values: state IDLE, `idx` 0, active table all 00, shadow table all 00.
- Output reset values: `M1` 2'b00, `out_valid` 0, `loaded` 0, `cfg_err` 0, `cfg_ready` 0 during reset.
- Lookup latency is 1 cycle; throughput is 1 lookup per cycle.
- A full load takes at least 16 cycles (one byte per cycle). The committed table is visible to a lookup issued in the cycle after the commit edge.
- Back-to-back loads need no gap. A byte accepted in the cycle after a commit starts the new load.
- `cfg_valid` low inside LOAD stalls the load without a timeout; `idx` holds.
- Reset mid-load abandons the load, clears both tables and `loaded`, and forces the outputs to their reset values at that edge.

## Test plan
- Reset, then `in_valid` = 1 with `M0` = 6'd37: next cycle `M1` = 00, `out_valid` = 1, `loaded` = 0.
- Load 16 bytes of 8'hE4 (entries 0,1,2,3 repeating), `cfg_last` on byte 15, then sweep `M0` 0..63 back-to-back:
  - `M1` = `M0[1:0]` for every code, each one cycle after its request.
  - `loaded` = 1 starting the cycle after byte 15.
- With the 8'hE4 table committed, start a load of all 8'h00 bytes with `cfg_last` asserted on byte 7:
  - `cfg_err` = 1, state IDLE.
  - Lookup of `M0` = 3 still returns 11.
  - The next accepted byte clears `cfg_err`.
- Load with no `cfg_last` on byte 15 (byte 15 = 8'hFF): `cfg_err` = 1 and the active table is unchanged.
- Commit a table of all 8'hFF bytes while issuing `M0` = 5 in the commit cycle and again in the next cycle:
  - First result is the old entry.
  - Second result is 11.
- Drop `cfg_valid` for 10 cycles after byte 6, then resume: the load completes normally with correct entries 24..63.
- Assert `rst` low after byte 9 of a load, release, then look up `M0` = 0: `M1` = 00, `loaded` = 0, `cfg_err` = 0.
